// File: rtl/watch_timekeeper_pkg.sv
// Shared constants, key FSM states and BCD/12-hour helpers for the watch timekeeper.
// Latency: pure declarations and combinational functions, no state.
// Backpressure: none; consumers evaluate the helpers every cycle.
package watch_pkg;

  // One-hot positions within digit_sel
  localparam int DIG_SEC0 = 0;
  localparam int DIG_SEC1 = 1;
  localparam int DIG_MIN0 = 2;
  localparam int DIG_MIN1 = 3;
  localparam int DIG_HRS0 = 4;
  localparam int DIG_HRS1 = 5;

  // Largest legal value of each time field
  localparam logic [5:0] SEC_MAX = 6'd59;
  localparam logic [5:0] MIN_MAX = 6'd59;
  localparam logic [5:0] HR_MAX  = 6'd23;

  typedef enum logic [1:0] {
    KR_IDLE   = 2'd0,
    KR_DELAY  = 2'd1,
    KR_REPEAT = 2'd2
  } kr_state_e;

  typedef struct packed {
    logic [4:0] hr;
    logic       pm;
  } hr12_t;

  // 0-59 to {tens, ones} BCD by repeated subtraction (at most five passes)
  function automatic logic [7:0] bin2bcd2(input logic [6:0] v);
    logic [3:0] tens;
    logic [6:0] rem;
    tens = 4'd0;
    rem  = v;
    for (int i = 0; i < 5; i++) begin
      if (rem >= 7'd10) begin
        rem  = rem - 7'd10;
        tens = tens + 4'd1;
      end
    end
    return {tens, rem[3:0]};
  endfunction

  // 24-hour value to 12-hour display hour plus PM flag
  function automatic hr12_t hr_to_12(input logic [4:0] h);
    hr12_t r;
    if (h == 5'd0) begin
      r.hr = 5'd12;
      r.pm = 1'b0;
    end else if (h < 5'd12) begin
      r.hr = h;
      r.pm = 1'b0;
    end else if (h == 5'd12) begin
      r.hr = 5'd12;
      r.pm = 1'b1;
    end else begin
      r.hr = h - 5'd12;
      r.pm = 1'b1;
    end
    return r;
  endfunction

  // +/-1 or +/-10 on a field modulo (lim+1), without any carry out
  function automatic logic [5:0] adj_mod(input logic [5:0] v, input logic [5:0] lim,
                                         input logic big, input logic inc);
    logic [6:0] d;
    logic [6:0] m;
    logic [6:0] r;
    d = big ? 7'd10 : 7'd1;
    m = {1'b0, lim} + 7'd1;
    r = inc ? ({1'b0, v} + d) : ({1'b0, v} + m - d);
    if (r >= m) r = r - m;
    return r[5:0];
  endfunction

endpackage

// File: rtl/watch_timekeeper_key_repeat.sv
// Key auto-repeat: one step on press, another after RPT_DLY held cycles, then every RPT_PER.
// Latency: step is combinational in the cycle the key is first seen high (no added delay).
// Backpressure: none; steps are single-cycle pulses the consumer may ignore.
module key_repeat
  import watch_pkg::*;
#(
  parameter int RPT_DLY = 3000000,
  parameter int RPT_PER = 1200000,
  parameter int RPT_W   = 22
) (
  input  logic clk,
  input  logic rst,
  input  logic key,
  output logic step
);

  localparam logic [RPT_W-1:0] DLY_C = RPT_W'(RPT_DLY);
  localparam logic [RPT_W-1:0] PER_C = RPT_W'(RPT_PER);
  localparam logic [RPT_W-1:0] ONE_C = RPT_W'(1);

  kr_state_e        state_q, state_d;
  logic [RPT_W-1:0] cnt_q, cnt_d;
  logic             key_q;
  logic             rise;

  assign rise = key & ~key_q;

  // State, timer and key history; key history resets high so a key held through reset needs a fresh press
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= KR_IDLE;
      cnt_q   <= '0;
      key_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      key_q   <= key;
    end
  end

  // Next state and step pulse; cnt counts cycles since the last emitted step
  always_comb begin
    step    = 1'b0;
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      KR_IDLE: begin
        if (rise) begin
          step    = 1'b1;
          cnt_d   = ONE_C;
          state_d = KR_DELAY;
        end
      end
      KR_DELAY: begin
        if (!key) begin
          state_d = KR_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DLY_C) begin
          step    = 1'b1;
          cnt_d   = ONE_C;
          state_d = KR_REPEAT;
        end else begin
          cnt_d = cnt_q + ONE_C;
        end
      end
      KR_REPEAT: begin
        if (!key) begin
          state_d = KR_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == PER_C) begin
          step  = 1'b1;
          cnt_d = ONE_C;
        end else begin
          cnt_d = cnt_q + ONE_C;
        end
      end
      default: begin
        state_d = KR_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: rtl/watch_timekeeper.sv
// HH:MM:SS timekeeper with prescaler, 12/24-hour display, set mode and key auto-repeat.
// Latency: time registers update on the tick/step edge; digits decode combinationally from them.
// Backpressure: none; tick_1hz is a free-running single-cycle pulse.
module watch_timekeeper
  import watch_pkg::*;
#(
  parameter int TICK_DIV = 6000000,
  parameter int CNT_W    = 23,
  parameter int RPT_DLY  = 3000000,
  parameter int RPT_PER  = 1200000,
  parameter int RPT_W    = 22
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic       mode_12h,
  input  logic       set_mode,
  input  logic [5:0] digit_sel,
  input  logic       up,
  input  logic       down,
  output logic [3:0] sec0,
  output logic [3:0] sec1,
  output logic [3:0] min0,
  output logic [3:0] min1,
  output logic [3:0] hrs0,
  output logic [3:0] hrs1,
  output logic       pm,
  output logic       tick_1hz
);

  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] PRE_ONE   = CNT_W'(1);

  logic [5:0]       sec_q, sec_d;
  logic [5:0]       min_q, min_d;
  logic [4:0]       hr_q, hr_d;
  logic [CNT_W-1:0] pre_q, pre_d;
  logic             tick_q, tick_d;
  logic             set_q;
  logic             blk_up_q, blk_up_d;
  logic             blk_dn_q, blk_dn_d;

  logic             up_step, dn_step;
  logic             counting, wrap, set_rise;
  logic             up_ok, dn_ok, sel_ok, adj_vld, adj_big;
  logic [5:0]       hr_adj;
  hr12_t            h12;
  logic [4:0]       hr_disp;
  logic [7:0]       sec_bcd, min_bcd, hr_bcd;

  key_repeat #(.RPT_DLY(RPT_DLY), .RPT_PER(RPT_PER), .RPT_W(RPT_W)) u_key_up (
    .clk  (clk),
    .rst  (rst),
    .key  (up),
    .step (up_step)
  );

  key_repeat #(.RPT_DLY(RPT_DLY), .RPT_PER(RPT_PER), .RPT_W(RPT_W)) u_key_dn (
    .clk  (clk),
    .rst  (rst),
    .key  (down),
    .step (dn_step)
  );

  assign counting = run & ~set_mode;
  assign wrap     = (pre_q == TICK_LAST);
  assign set_rise = set_mode & ~set_q;

  // A key already down when set mode is entered stays muted until it is released
  assign up_ok   = up_step & set_mode & ~blk_up_q & ~(set_rise & up);
  assign dn_ok   = dn_step & set_mode & ~blk_dn_q & ~(set_rise & down);
  assign sel_ok  = (digit_sel != 6'd0) && ((digit_sel & (digit_sel - 6'd1)) == 6'd0);
  assign adj_vld = sel_ok & (up_ok ^ dn_ok);
  assign adj_big = digit_sel[DIG_SEC1] | digit_sel[DIG_MIN1] | digit_sel[DIG_HRS1];
  assign hr_adj  = adj_mod({1'b0, hr_q}, HR_MAX, adj_big, up_ok);

  // Next-state for prescaler, tick and time fields; ticking and adjusting never coincide
  always_comb begin
    pre_d    = '0;
    tick_d   = 1'b0;
    sec_d    = sec_q;
    min_d    = min_q;
    hr_d     = hr_q;
    blk_up_d = blk_up_q;
    blk_dn_d = blk_dn_q;

    if (!up)           blk_up_d = 1'b0;
    else if (set_rise) blk_up_d = 1'b1;
    if (!down)         blk_dn_d = 1'b0;
    else if (set_rise) blk_dn_d = 1'b1;

    if (counting) begin
      if (wrap) begin
        pre_d  = '0;
        tick_d = 1'b1;
        if (sec_q == SEC_MAX) begin
          sec_d = 6'd0;
          if (min_q == MIN_MAX) begin
            min_d = 6'd0;
            hr_d  = (hr_q == HR_MAX[4:0]) ? 5'd0 : hr_q + 5'd1;
          end else begin
            min_d = min_q + 6'd1;
          end
        end else begin
          sec_d = sec_q + 6'd1;
        end
      end else begin
        pre_d = pre_q + PRE_ONE;
      end
    end

    if (adj_vld) begin
      if (digit_sel[DIG_SEC0] | digit_sel[DIG_SEC1]) sec_d = adj_mod(sec_q, SEC_MAX, adj_big, up_ok);
      if (digit_sel[DIG_MIN0] | digit_sel[DIG_MIN1]) min_d = adj_mod(min_q, MIN_MAX, adj_big, up_ok);
      if (digit_sel[DIG_HRS0] | digit_sel[DIG_HRS1]) hr_d  = hr_adj[4:0];
    end
  end

  // Time, prescaler, tick and key-gating registers
  always_ff @(posedge clk) begin
    if (rst) begin
      sec_q    <= 6'd0;
      min_q    <= 6'd0;
      hr_q     <= 5'd0;
      pre_q    <= '0;
      tick_q   <= 1'b0;
      set_q    <= 1'b0;
      blk_up_q <= 1'b0;
      blk_dn_q <= 1'b0;
    end else begin
      sec_q    <= sec_d;
      min_q    <= min_d;
      hr_q     <= hr_d;
      pre_q    <= pre_d;
      tick_q   <= tick_d;
      set_q    <= set_mode;
      blk_up_q <= blk_up_d;
      blk_dn_q <= blk_dn_d;
    end
  end

  // Display decode only; mode_12h never touches stored time
  assign h12     = hr_to_12(hr_q);
  assign hr_disp = mode_12h ? h12.hr : hr_q;
  assign sec_bcd = bin2bcd2({1'b0, sec_q});
  assign min_bcd = bin2bcd2({1'b0, min_q});
  assign hr_bcd  = bin2bcd2({2'b00, hr_disp});

  assign sec0     = sec_bcd[3:0];
  assign sec1     = sec_bcd[7:4];
  assign min0     = min_bcd[3:0];
  assign min1     = min_bcd[7:4];
  assign hrs0     = hr_bcd[3:0];
  assign hrs1     = hr_bcd[7:4];
  assign pm       = mode_12h & h12.pm;
  assign tick_1hz = tick_q;

endmodule

// File: tb/tb_watch_timekeeper.sv
// Bench for watch_timekeeper: directed stimulus pushes expected displays, a monitor compares.
// Latency: expectations are tagged with the cycle at which the display must hold them.
// Backpressure: none.
module tb_watch_timekeeper;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       run = 1'b0;
  logic       mode_12h = 1'b0;
  logic       set_mode = 1'b0;
  logic [5:0] digit_sel = 6'd0;
  logic       up = 1'b0;
  logic       down = 1'b0;
  logic [3:0] sec0, sec1, min0, min1, hrs0, hrs1;
  logic       pm, tick_1hz;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    string nm;
    int    cyc;
    int    h;
    int    m;
    int    s;
    logic  p;
    logic  t;
  } exp_t;

  exp_t sbq[$];
  exp_t m_e;
  int   a_h, a_m, a_s;

  watch_timekeeper #(.TICK_DIV(4), .CNT_W(3), .RPT_DLY(6), .RPT_PER(3), .RPT_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
    .mode_12h  (mode_12h),
    .set_mode  (set_mode),
    .digit_sel (digit_sel),
    .up        (up),
    .down      (down),
    .sec0      (sec0),
    .sec1      (sec1),
    .min0      (min0),
    .min1      (min1),
    .hrs0      (hrs0),
    .hrs1      (hrs1),
    .pm        (pm),
    .tick_1hz  (tick_1hz)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pop every expectation due this cycle and compare against the display
  always @(negedge clk) begin
    while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
      m_e = sbq.pop_front();
      a_h = int'(hrs1) * 10 + int'(hrs0);
      a_m = int'(min1) * 10 + int'(min0);
      a_s = int'(sec1) * 10 + int'(sec0);
      checks++;
      if (a_h != m_e.h || a_m != m_e.m || a_s != m_e.s || pm !== m_e.p || tick_1hz !== m_e.t) begin
        errors++;
        $display("FAIL %s: got %0d:%0d:%0d pm=%0b tick=%0b, want %0d:%0d:%0d pm=%0b tick=%0b",
                 m_e.nm, a_h, a_m, a_s, pm, tick_1hz, m_e.h, m_e.m, m_e.s, m_e.p, m_e.t);
      end
    end
  end

  task automatic tk(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_at(input string nm, input int h, input int m, input int s,
                           input logic p, input logic t);
    exp_t e;
    e.nm = nm; e.cyc = cyc; e.h = h; e.m = m; e.s = s; e.p = p; e.t = t;
    sbq.push_back(e);
  endtask

  task automatic sel(input int idx);
    digit_sel = 6'd1 << idx;
  endtask

  task automatic press(input logic is_up);
    if (is_up) up = 1'b1; else down = 1'b1;
    tk(1);
    up = 1'b0;
    down = 1'b0;
    tk(1);
  endtask

  initial begin
    // Reset
    tk(2);
    rst = 1'b0;
    expect_at("reset_24h", 0, 0, 0, 1'b0, 1'b0);
    tk(1);
    mode_12h = 1'b1;
    expect_at("reset_12h", 12, 0, 0, 1'b0, 1'b0);
    tk(1);
    mode_12h = 1'b0;

    // Counting: tick every 4 cycles, seconds follow
    run = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tk(3);
      expect_at("count_gap", 0, 0, k - 1, 1'b0, 1'b0);
      tk(1);
      expect_at("count_tick", 0, 0, k, 1'b0, 1'b1);
    end
    run = 1'b0;

    // Preload 23:59:58 from 00:00:10
    set_mode = 1'b1;
    tk(1);
    sel(4); press(1'b0);
    expect_at("hr0_down_wrap", 23, 0, 10, 1'b0, 1'b0);
    tk(1);
    mode_12h = 1'b1;
    expect_at("hr0_down_wrap_12h", 11, 0, 10, 1'b1, 1'b0);
    tk(1);
    mode_12h = 1'b0;
    sel(2); press(1'b0);
    sel(1); press(1'b0);
    sel(0); press(1'b0); press(1'b0);
    expect_at("preload", 23, 59, 58, 1'b0, 1'b0);

    // Rollover in 24-hour mode, first tick 4 cycles after set mode ends
    set_mode = 1'b0;
    run = 1'b1;
    tk(3);
    expect_at("roll_wait", 23, 59, 58, 1'b0, 1'b0);
    tk(1);
    expect_at("roll_59", 23, 59, 59, 1'b0, 1'b1);
    tk(3);
    expect_at("roll_hold", 23, 59, 59, 1'b0, 1'b0);
    tk(1);
    expect_at("roll_zero", 0, 0, 0, 1'b0, 1'b1);
    run = 1'b0;

    // Rollover in 12-hour mode
    set_mode = 1'b1;
    tk(1);
    sel(4); press(1'b0);
    sel(2); press(1'b0);
    sel(0); press(1'b0); press(1'b0);
    mode_12h = 1'b1;
    set_mode = 1'b0;
    run = 1'b1;
    tk(4);
    expect_at("roll12_59", 11, 59, 59, 1'b1, 1'b1);
    tk(4);
    expect_at("roll12_zero", 12, 0, 0, 1'b0, 1'b1);
    run = 1'b0;
    tk(1);
    mode_12h = 1'b0;

    // Adjust wraps, no carries between fields
    set_mode = 1'b1;
    tk(1);
    sel(0);
    repeat (5) press(1'b0);
    expect_at("sec0_down_x5", 0, 0, 55, 1'b0, 1'b0);
    sel(1); press(1'b1);
    expect_at("sec1_up_wrap", 0, 0, 5, 1'b0, 1'b0);
    press(1'b0);
    expect_at("sec1_down_wrap", 0, 0, 55, 1'b0, 1'b0);
    press(1'b1);
    expect_at("sec1_up_again", 0, 0, 5, 1'b0, 1'b0);
    sel(3); press(1'b0);
    expect_at("min1_down_wrap", 0, 50, 5, 1'b0, 1'b0);
    sel(5); press(1'b1);
    expect_at("hr1_up_10", 10, 50, 5, 1'b0, 1'b0);
    press(1'b1);
    expect_at("hr1_up_20", 20, 50, 5, 1'b0, 1'b0);
    press(1'b1);
    expect_at("hr1_up_wrap", 6, 50, 5, 1'b0, 1'b0);

    // Auto-repeat: steps at press, +6, +9, +12, +15
    sel(0);
    up = 1'b1;
    tk(1);
    expect_at("rpt_first", 6, 50, 6, 1'b0, 1'b0);
    tk(5);
    expect_at("rpt_delay", 6, 50, 6, 1'b0, 1'b0);
    tk(1);
    expect_at("rpt_6", 6, 50, 7, 1'b0, 1'b0);
    tk(3);
    expect_at("rpt_9", 6, 50, 8, 1'b0, 1'b0);
    tk(3);
    expect_at("rpt_12", 6, 50, 9, 1'b0, 1'b0);
    tk(3);
    expect_at("rpt_15", 6, 50, 10, 1'b0, 1'b0);
    up = 1'b0;
    tk(4);
    expect_at("rpt_release", 6, 50, 10, 1'b0, 1'b0);
    press(1'b1);
    tk(8);
    expect_at("rpt_single", 6, 50, 11, 1'b0, 1'b0);

    // Illegal selects and simultaneous keys
    digit_sel = 6'b000011;
    press(1'b1);
    expect_at("sel_two_hot", 6, 50, 11, 1'b0, 1'b0);
    digit_sel = 6'b000000;
    press(1'b0);
    expect_at("sel_none", 6, 50, 11, 1'b0, 1'b0);
    sel(0);
    up = 1'b1;
    down = 1'b1;
    tk(1);
    expect_at("both_press", 6, 50, 11, 1'b0, 1'b0);
    tk(8);
    expect_at("both_held", 6, 50, 11, 1'b0, 1'b0);
    up = 1'b0;
    down = 1'b0;
    tk(1);

    // Key held across set mode entry stays muted until re-pressed
    set_mode = 1'b0;
    tk(1);
    up = 1'b1;
    tk(2);
    set_mode = 1'b1;
    tk(12);
    expect_at("held_into_set", 6, 50, 11, 1'b0, 1'b0);
    up = 1'b0;
    tk(1);
    press(1'b1);
    expect_at("held_repress", 6, 50, 12, 1'b0, 1'b0);

    // Freeze: no ticks in set mode, first tick 4 cycles after leaving it
    run = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tk(1);
      expect_at("freeze", 6, 50, 12, 1'b0, 1'b0);
    end
    set_mode = 1'b0;
    tk(3);
    expect_at("unfreeze_wait", 6, 50, 12, 1'b0, 1'b0);
    tk(1);
    expect_at("unfreeze_tick", 6, 50, 13, 1'b0, 1'b1);
    run = 1'b0;

    // Reset during a held key
    set_mode = 1'b1;
    tk(1);
    sel(0);
    up = 1'b1;
    tk(3);
    expect_at("pre_rst_step", 6, 50, 14, 1'b0, 1'b0);
    rst = 1'b1;
    tk(1);
    expect_at("rst_mid", 0, 0, 0, 1'b0, 1'b0);
    rst = 1'b0;
    tk(10);
    expect_at("rst_held_key", 0, 0, 0, 1'b0, 1'b0);
    up = 1'b0;
    tk(1);
    press(1'b1);
    expect_at("rst_repress", 0, 0, 1, 1'b0, 1'b0);

    // Drain the scoreboard within a bounded number of cycles
    for (int i = 0; i < 10 && sbq.size() > 0; i++) @(negedge clk);
    #1;
    if (sbq.size() > 0) begin
      $display("FAIL drain: %0d expectations left unchecked, want 0", sbq.size());
      checks += sbq.size();
      errors += sbq.size();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
